// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_pkg
//  Description : Shared types, defaults and address decode helper for the
//                boot ROM read stage.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_pkg;

    localparam int unsigned ROM_WORDS_DEFAULT   = 2048;
    localparam int unsigned ROM_LATENCY_DEFAULT = 1;
    localparam int unsigned ROM_DATA_W_DEFAULT  = 64;
    // Widest byte address the decode helper understands.
    localparam int unsigned ROM_ADDR_W_MAX      = 128;

    // Response entry held in the response FIFO.
    typedef struct packed {
        logic [ROM_DATA_W_DEFAULT-1:0] data;
        logic                          err;
    } rom_rsp_t;

    // Result of decoding a byte address into a ROM word index.
    typedef struct packed {
        logic [31:0] idx;
        logic        oor;
    } rom_idx_t;

    // Word index is the byte address shifted by the word-offset bits. The
    // address is out of range if any bit above the index field is set or the
    // index reaches past the last ROM word.
    function automatic rom_idx_t rom_idx(
        input logic [ROM_ADDR_W_MAX-1:0] addr,
        input int unsigned               off_bits,
        input int unsigned               idx_w,
        input int unsigned               words
    );
        logic [ROM_ADDR_W_MAX-1:0] word;
        rom_idx_t                  r;
        word  = addr >> off_bits;
        r.idx = word[31:0];
        r.oor = ((word >> idx_w) != '0) ||
                (word >= {{(ROM_ADDR_W_MAX-32){1'b0}}, words});
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rom_rsp_fifo
//  Description : Depth-entry synchronous FIFO with registered storage, no
//                fall-through, full/empty flags and same-cycle push/pop.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_rsp_fifo
    import rom_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter type         T     = rom_rsp_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     pop_data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = $clog2(Depth + 1);

    T                 mem_q [Depth];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o     = (count_q == CNT_W'(Depth));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is honoured only when the head leaves this cycle.
    assign w_do_push = push_i && (!full_o || pop_i);
    assign w_do_pop  = pop_i && !empty_o;

    // Storage, pointers (wrap naturally since Depth is a power of two) and fill count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_read_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : rom_read_pipeline
//  Description : Read stage between the bridge request port and the boot ROM.
//                Issues word reads to a fixed-latency ROM, tracks them through
//                a latency pipe and returns them in order via a response FIFO,
//                with credits bounding outstanding reads to the FIFO depth.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_read_pipeline
    import rom_pkg::*;
#(
    parameter  int unsigned AddrWidth  = 64,
    parameter  int unsigned DataWidth  = ROM_DATA_W_DEFAULT,
    parameter  int unsigned RomWords   = ROM_WORDS_DEFAULT,
    parameter  int unsigned RomLatency = ROM_LATENCY_DEFAULT,
    parameter  int unsigned Depth      = 4,
    localparam int unsigned IdxWidth   = $clog2(RomWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 rom_req_o,
    output logic [IdxWidth-1:0]  rom_addr_o,
    input  logic [DataWidth-1:0] rom_rdata_i
);

    localparam int unsigned OFF_BITS = $clog2(DataWidth / 8);
    localparam int unsigned CNT_W    = $clog2(Depth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 err;
    } rsp_t;

    rom_idx_t          w_idx;
    logic              w_idx_unused;
    logic              w_accept;
    logic              w_pop;
    logic              w_push;
    rsp_t              w_push_rsp;
    rsp_t              w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  credit_q;
    logic [CNT_W-1:0]  credit_d;
    logic [RomLatency-1:0] pipe_vld_q;
    logic [RomLatency-1:0] pipe_err_q;

    assign w_idx        = rom_idx(ROM_ADDR_W_MAX'(req_addr_i), OFF_BITS, IdxWidth, RomWords);
    // Only the low IdxWidth index bits drive the ROM; the rest feed the range check.
    assign w_idx_unused = ^w_idx.idx;

    // Ready depends on registered credits only, never on this cycle's handshakes.
    assign req_ready_o = (credit_q < CNT_W'(Depth));
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_pop       = rsp_valid_o && rsp_ready_i;

    assign rom_req_o  = w_accept && !w_idx.oor;
    assign rom_addr_o = rom_req_o ? w_idx.idx[IdxWidth-1:0] : '0;

    // The oldest pipe stage lines up with the ROM data for that request.
    assign w_push          = pipe_vld_q[RomLatency-1];
    assign w_push_rsp.err  = pipe_err_q[RomLatency-1];
    assign w_push_rsp.data = pipe_err_q[RomLatency-1] ? '0 : rom_rdata_i;

    assign rsp_valid_o = !w_fifo_empty;
    assign rsp_data_o  = w_head.data;
    assign rsp_err_o   = w_head.err;

    // Latency pipe: shift {valid, err} so each accept reaches the FIFO when its data arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
        end else begin
            pipe_vld_q[0] <= w_accept;
            pipe_err_q[0] <= w_idx.oor;
            for (int i = 1; i < int'(RomLatency); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_err_q[i] <= pipe_err_q[i-1];
            end
        end
    end

    // Next credit count: one per accept, returned on pop, unchanged when both happen.
    always_comb begin
        credit_d = credit_q;
        if (w_accept && !w_pop) begin
            credit_d = credit_q + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            credit_d = credit_q - CNT_W'(1);
        end
    end

    // Credit register counting reads in flight plus responses queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    rom_rsp_fifo #(
        .Depth (Depth),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_rsp),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty)
    );

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        w_push |-> !w_fifo_full);
    a_no_credit_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        w_pop |-> (credit_q != '0));
    a_no_oor_rom_req: assert property (@(posedge clk_i) disable iff (rst_i)
        rom_req_o |-> !w_idx.oor);

endmodule
`default_nettype wire

// File: tb/tb_rom_read_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_read_pipeline
//  Description : Self-checking bench for rom_read_pipeline; one instance with
//                default latency and one with ROM latency 3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_read_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        rsp_ready;

    always #5 clk = ~clk;

    logic        rv0, ready0, rsp_valid0, err0, rom_req0;
    logic [63:0] data0, rdata0;
    logic [10:0] rom_addr0;
    logic        rv1, ready1, rsp_valid1, err1, rom_req1;
    logic [63:0] data1, rdata1;
    logic [10:0] rom_addr1;

    assign rv0 = req_valid & ~sel;
    assign rv1 = req_valid & sel;

    rom_read_pipeline u_dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (rv0), .req_ready_o (ready0), .req_addr_i (req_addr),
        .rsp_valid_o (rsp_valid0), .rsp_ready_i (rsp_ready),
        .rsp_data_o (data0), .rsp_err_o (err0),
        .rom_req_o (rom_req0), .rom_addr_o (rom_addr0), .rom_rdata_i (rdata0)
    );

    rom_read_pipeline #(.RomLatency(3)) u_dut3 (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (rv1), .req_ready_o (ready1), .req_addr_i (req_addr),
        .rsp_valid_o (rsp_valid1), .rsp_ready_i (rsp_ready),
        .rsp_data_o (data1), .rsp_err_o (err1),
        .rom_req_o (rom_req1), .rom_addr_o (rom_addr1), .rom_rdata_i (rdata1)
    );

    // Outputs of the instance currently under test.
    logic        c_ready, c_rsp_valid, c_err, c_rom_req;
    logic [63:0] c_data;
    logic [10:0] c_rom_addr;
    assign c_ready     = sel ? ready1     : ready0;
    assign c_rsp_valid = sel ? rsp_valid1 : rsp_valid0;
    assign c_err       = sel ? err1       : err0;
    assign c_rom_req   = sel ? rom_req1   : rom_req0;
    assign c_data      = sel ? data1      : data0;
    assign c_rom_addr  = sel ? rom_addr1  : rom_addr0;

    // Behavioural ROM content.
    function automatic logic [63:0] rom_word(input logic [10:0] i);
        return {32'hDEADBEEF, 21'd0, i};
    endfunction

    // Fixed-latency ROM models: data for the sampled index appears LAT cycles later.
    logic [10:0] rp0;
    logic [10:0] rp1 [3];
    always @(posedge clk) begin
        rp0    <= rom_addr0;
        rp1[0] <= rom_addr1;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign rdata0 = rom_word(rp0);
    assign rdata1 = rom_word(rp1[2]);

    // Reference model: every accepted request, oldest first, with its accept cycle.
    typedef struct {
        logic [63:0] data;
        bit          err;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          errors;
    int          checks;
    bit          hold_pending;
    logic [63:0] held_data;
    logic        held_err;

    function automatic exp_t expect_of(input logic [63:0] a, input int t);
        exp_t e;
        e.err  = (a / 64'd8) >= 64'd2048;
        e.data = e.err ? 64'd0 : rom_word(a[13:3]);
        e.t    = t;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [63:0] a, input bit rr);
        @(negedge clk);
        cyc++;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        #1;
    endtask

    // Random traffic against the model: vp/rp/op are percentages of valid,
    // consumer-ready and out-of-range addresses.
    task automatic test_traffic(input int n, input int vp, input int rp, input int op);
        for (int k = 0; k < n; k++) begin
            bit          v, rr, acc, exp_valid;
            logic [63:0] a;
            int          lat;
            exp_t        e;
            v  = ($urandom_range(0, 99) < vp);
            rr = ($urandom_range(0, 99) < rp);
            if ($urandom_range(0, 99) < op) begin
                if ($urandom_range(0, 1) == 1)
                    a = 64'h4000 + 64'($urandom_range(0, 32'h7FFF_FFFF));
                else
                    a = {32'($urandom), 32'($urandom)} | 64'h8000_0000_0000_0000;
            end else begin
                a = 64'($urandom_range(0, 2047)) * 64'd8 + 64'($urandom_range(0, 7));
            end
            drive(v, a, rr);
            lat = sel ? 3 : 1;
            e   = expect_of(a, cyc);

            checks++;
            if (c_ready !== (q.size() < 4)) begin
                errors++;
                $display("FAIL traffic_ready cyc=%0d: got %b expected %b", cyc, c_ready, q.size() < 4);
            end
            acc       = v && c_ready;
            exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= lat + 1);

            checks++;
            if (c_rsp_valid !== exp_valid) begin
                errors++;
                $display("FAIL traffic_rsp_valid cyc=%0d: got %b expected %b", cyc, c_rsp_valid, exp_valid);
            end

            checks++;
            if ((c_rom_req !== (acc && !e.err)) || (acc && !e.err && (c_rom_addr !== a[13:3]))) begin
                errors++;
                $display("FAIL traffic_rom_req cyc=%0d: got req=%b idx=%h expected req=%b idx=%h",
                         cyc, c_rom_req, c_rom_addr, acc && !e.err, a[13:3]);
            end

            if (hold_pending) begin
                checks++;
                if ((c_data !== held_data) || (c_err !== held_err)) begin
                    errors++;
                    $display("FAIL traffic_hold cyc=%0d: got %h/%b expected %h/%b",
                             cyc, c_data, c_err, held_data, held_err);
                end
            end

            if (c_rsp_valid && exp_valid) begin
                checks++;
                if ((c_data !== q[0].data) || (c_err !== q[0].err)) begin
                    errors++;
                    $display("FAIL traffic_rsp_data cyc=%0d: got %h/%b expected %h/%b",
                             cyc, c_data, c_err, q[0].data, q[0].err);
                end
            end

            hold_pending = c_rsp_valid && !rr;
            held_data    = c_data;
            held_err     = c_err;
            if (c_rsp_valid && rr && (q.size() > 0)) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ready0 !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b expected 1", ready0); end
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid0); end
        checks++; if (err0 !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b expected 0", err0); end
        checks++; if (data0 !== 64'd0)     begin errors++; $display("FAIL reset_data: got %h expected 0", data0); end
        checks++; if (rom_req0 !== 1'b0)   begin errors++; $display("FAIL reset_rom_req: got %b expected 0", rom_req0); end
        checks++; if (rom_addr0 !== 11'd0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr0); end
        checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_lat3: got %b expected 0", rsp_valid1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        sel = 1'b0;
        drive(1'b1, 64'h18, 1'b1);
        checks++;
        if ((rom_req0 !== 1'b1) || (rom_addr0 !== 11'd3)) begin
            errors++; $display("FAIL single_rom_req: got req=%b idx=%h expected req=1 idx=003", rom_req0, rom_addr0);
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid0); end
        drive(1'b0, 64'h0, 1'b1);
        checks++;
        if ((rsp_valid0 !== 1'b1) || (data0 !== 64'hDEADBEEF_00000003) || (err0 !== 1'b0)) begin
            errors++; $display("FAIL single_rsp: got v=%b %h/%b expected v=1 deadbeef00000003/0", rsp_valid0, data0, err0);
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL single_after_pop: got %b expected 0", rsp_valid0); end
    endtask

    task automatic test_backpressure();
        int          k;
        logic [63:0] a;
        exp_t        bq[$];
        sel = 1'b0;
        k   = 0;
        for (int c = 0; c < 6; c++) begin
            a = 64'(20 + k) * 64'd8;
            drive(1'b1, a, 1'b0);
            if (c >= 4) begin
                checks++;
                if (ready0 !== 1'b0) begin errors++; $display("FAIL bp_ready_full c=%0d: got %b expected 0", c, ready0); end
            end
            if (ready0) begin
                bq.push_back(expect_of(a, cyc));
                k++;
            end
        end
        checks++; if (k !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", k); end
        drive(1'b0, 64'h0, 1'b0);
        drive(1'b0, 64'h0, 1'b0);
        drive(1'b0, 64'h0, 1'b1);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL bp_ready_pop_cycle: got %b expected 0", ready0); end
        checks++;
        if ((rsp_valid0 !== 1'b1) || (bq.size() == 0) || (data0 !== bq[0].data)) begin
            errors++; $display("FAIL bp_first_rsp: got v=%b %h", rsp_valid0, data0);
        end
        if (bq.size() > 0) void'(bq.pop_front());
        drive(1'b0, 64'h0, 1'b1);
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", ready0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ((rsp_valid0 !== 1'b1) || (bq.size() == 0) || (data0 !== bq[0].data) || (err0 !== 1'b0)) begin
                errors++; $display("FAIL bp_order i=%0d: got v=%b %h/%b", i, rsp_valid0, data0, err0);
            end
            if (bq.size() > 0) void'(bq.pop_front());
            if (i < 2) drive(1'b0, 64'h0, 1'b1);
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", rsp_valid0); end
    endtask

    task automatic test_out_of_range();
        sel = 1'b0;
        drive(1'b1, 64'h4000, 1'b1);
        checks++;
        if ((rom_req0 !== 1'b0) || (rom_addr0 !== 11'd0)) begin
            errors++; $display("FAIL oor_rom_req: got req=%b idx=%h expected req=0 idx=000", rom_req0, rom_addr0);
        end
        drive(1'b1, 64'h20, 1'b1);
        checks++;
        if ((rom_req0 !== 1'b1) || (rom_addr0 !== 11'd4)) begin
            errors++; $display("FAIL oor_next_rom_req: got req=%b idx=%h expected req=1 idx=004", rom_req0, rom_addr0);
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++;
        if ((rsp_valid0 !== 1'b1) || (err0 !== 1'b1) || (data0 !== 64'd0)) begin
            errors++; $display("FAIL oor_rsp: got v=%b %h/%b expected v=1 0/1", rsp_valid0, data0, err0);
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++;
        if ((rsp_valid0 !== 1'b1) || (err0 !== 1'b0) || (data0 !== rom_word(11'd4))) begin
            errors++; $display("FAIL oor_next_rsp: got v=%b %h/%b expected v=1 %h/0", rsp_valid0, data0, err0, rom_word(11'd4));
        end
        drive(1'b0, 64'h0, 1'b1);
        hold_pending = 1'b0;
        test_traffic(200, 70, 70, 30);
        test_traffic(10, 0, 100, 0);
    endtask

    task automatic test_full_steady();
        sel = 1'b0;
        test_traffic(6, 100, 0, 0);
        test_traffic(100, 100, 100, 0);
        test_traffic(10, 0, 100, 0);
        checks++;
        if ((q.size() != 0) || (rsp_valid0 !== 1'b0)) begin
            errors++; $display("FAIL full_drain: got outstanding=%0d v=%b expected 0/0", q.size(), rsp_valid0);
        end
    endtask

    task automatic test_latency3();
        sel = 1'b1;
        hold_pending = 1'b0;
        drive(1'b1, 64'h18, 1'b1);
        checks++;
        if ((rom_req1 !== 1'b1) || (rom_addr1 !== 11'd3)) begin
            errors++; $display("FAIL lat3_rom_req: got req=%b idx=%h expected req=1 idx=003", rom_req1, rom_addr1);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            checks++; if (rsp_valid1 !== 1'b0) begin errors++; $display("FAIL lat3_early T+%0d: got %b expected 0", i, rsp_valid1); end
        end
        drive(1'b0, 64'h0, 1'b1);
        checks++;
        if ((rsp_valid1 !== 1'b1) || (data1 !== 64'hDEADBEEF_00000003) || (err1 !== 1'b0)) begin
            errors++; $display("FAIL lat3_rsp T+4: got v=%b %h/%b expected v=1 deadbeef00000003/0", rsp_valid1, data1, err1);
        end
        drive(1'b0, 64'h0, 1'b1);
        test_traffic(4, 100, 100, 0);
        test_traffic(8, 0, 100, 0);
        test_traffic(150, 60, 60, 20);
        test_traffic(12, 0, 100, 0);
        sel = 1'b0;
    endtask

    task automatic test_reset_midflight();
        sel = 1'b0;
        hold_pending = 1'b0;
        drive(1'b1, 64'h40, 1'b0);
        drive(1'b1, 64'h48, 1'b0);
        drive(1'b1, 64'h50, 1'b0);
        drive(1'b0, 64'h0, 1'b0);
        drive(1'b0, 64'h0, 1'b0);
        checks++; if (rsp_valid0 !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", rsp_valid0); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ((ready0 !== 1'b1) || (rsp_valid0 !== 1'b0) || (err0 !== 1'b0) || (data0 !== 64'd0) || (rom_req0 !== 1'b0)) begin
            errors++; $display("FAIL mid_async_reset: got rdy=%b v=%b err=%b data=%h req=%b", ready0, rsp_valid0, err0, data0, rom_req0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        hold_pending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1);
            checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL mid_stale_valid i=%0d: got %b expected 0", i, rsp_valid0); end
        end
        test_traffic(40, 60, 80, 10);
        test_traffic(10, 0, 100, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        hold_pending = 1'b0;
        test_reset();
        test_single_read();
        test_backpressure();
        test_out_of_range();
        test_full_steady();
        test_latency3();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
